// File: rtl/inv_pkg.sv
// Shared constants and types for units that sit in front of the Q8.24 reciprocal pipeline.
package inv_pkg;

    localparam int unsigned INV_N   = 4;
    localparam int unsigned INV_TW  = 2;
    localparam int unsigned INV_LAT = 24;

    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] HALF = 32'h0080_0000;

    typedef logic [INV_TW-1:0] tag_t;

endpackage

// File: rtl/inv_share_arbiter_if.sv
// Requester, response and pipeline-side signals of the shared reciprocal arbiter.
interface inv_share_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 5
);
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            hold;
    logic [31:0]     inv_a;
    logic            inv_new_data;
    logic [31:0]     inv_r;
    logic            inv_output_valid;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            busy;
    logic [CW-1:0]   inflight;
    logic            err;

    modport master (
        output req_valid, req_data, hold, inv_r, inv_output_valid,
        input  req_ready, inv_a, inv_new_data, rsp_valid, rsp_data, busy, inflight, err
    );

    modport slave (
        input  req_valid, req_data, hold, inv_r, inv_output_valid,
        output req_ready, inv_a, inv_new_data, rsp_valid, rsp_data, busy, inflight, err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, pointer advances past each winner.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned TW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          hold,
    output logic [N-1:0]  grant,
    output logic [TW-1:0] grant_idx,
    output logic          grant_valid
);
    localparam logic [TW:0]   NUM  = (TW + 1)'(N);
    localparam logic [TW-1:0] LAST = TW'(N - 1);

    logic [TW-1:0] ptr_q, ptr_d;
    logic [TW:0]   cand;
    logic [TW-1:0] pick;
    logic          found;

    // Scan from ptr upward; wrap at N, not at 2^TW.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (TW + 1)'(k);
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            if (!found && req[cand[TW-1:0]]) begin
                found = 1'b1;
                pick  = cand[TW-1:0];
            end
        end
    end

    always_comb begin
        grant_valid = found && !hold && !rst;
        grant_idx   = pick;
        grant       = '0;
        if (grant_valid) begin
            grant[pick] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_valid) begin
            ptr_d = (pick == LAST) ? '0 : pick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/inv_share_arbiter.sv
// Shares one fixed-latency reciprocal pipeline among N requesters; tags ride a delay line
// alongside the pipeline so each result returns to the requester that issued it.
module inv_share_arbiter
    import inv_pkg::*;
#(
    parameter int unsigned N   = INV_N,
    parameter int unsigned LAT = INV_LAT,
    parameter int unsigned TW  = INV_TW,
    parameter int unsigned CW  = $clog2(LAT + 2)
) (
    input logic                clk,
    input logic                rst,
    inv_share_arbiter_if.slave bus
);
    logic [N-1:0]  grant;
    logic [TW-1:0] grant_idx;
    logic          grant_valid;

    rr_arbiter #(
        .N (N),
        .TW(TW)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.req_valid),
        .hold       (bus.hold),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign bus.req_ready = grant;

    logic [31:0]   operand;
    logic [31:0]   inv_a_q;
    logic [31:0]   rsp_data_q;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          err_q;

    // Stage 0 is loaded at the transfer edge together with the operand register, so it doubles
    // as the issue strobe; the pipeline samples one edge later, hence LAT+1 entries so that the
    // last one lines up with inv_output_valid.
    logic [LAT:0]  tv_q;
    logic [TW-1:0] tag_q [LAT+1];
    logic          retire;
    logic [TW-1:0] ret_tag;

    assign operand = bus.req_data[{grant_idx, 5'd0} +: 32];
    assign retire  = tv_q[LAT];
    assign ret_tag = tag_q[LAT];

    always_comb begin
        rsp_valid_d = '0;
        if (bus.inv_output_valid && retire) begin
            rsp_valid_d[ret_tag] = 1'b1;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (grant_valid && !retire) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!grant_valid && retire) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_a_q     <= '0;
            tv_q        <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            if (grant_valid) begin
                inv_a_q <= operand;
            end
            tv_q     <= {tv_q[LAT-1:0], grant_valid};
            tag_q[0] <= grant_idx;
            for (int k = 1; k <= LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            rsp_valid_q <= rsp_valid_d;
            if (bus.inv_output_valid && retire) begin
                rsp_data_q <= bus.inv_r;
            end
            inflight_q <= inflight_d;
            // A result without a tag (or a tag without a result) means the pipeline lost sync.
            if (bus.inv_output_valid != retire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.inv_a        = inv_a_q;
    assign bus.inv_new_data = tv_q[0];
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.inflight     = inflight_q;
    assign bus.err          = err_q;
    assign bus.busy         = (inflight_q != '0) || tv_q[0];

endmodule
